// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    // Controller FSM: normal flow, or waiting on a multi-cycle memory access.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    // Integer x0 is hardwired to zero and never creates a dependency.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Stage-register controls driven by the controller.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_sel;
    } stall_ctrl_t;

    // Free-running pipeline: everything advances, no bubbles.
    localparam stall_ctrl_t CTRL_FLOW = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_sel: 1'b0
    };

    // Memory wait: freeze PC..EX_MEM, feed a bubble into MEM_WB.
    localparam stall_ctrl_t CTRL_MEM_STALL = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_sel: 1'b1
    };

    // Held in reset: nothing advances, every stage is bubbled.
    localparam stall_ctrl_t CTRL_RESET = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_sel: 1'b1
    };

endpackage

// File: rtl/hazard_stall_ctrl_luh_detect.sv
// Load-use comparator for one ID-stage source operand against the EX-stage destination.
module luh_detect
    import hazard_pkg::*;
(
    input  logic [4:0] rs_addr,
    input  logic       rs_use,
    input  logic       rs_f,
    input  logic [4:0] rd_addr,
    input  logic       rd_wren_int,
    input  logic       rd_wren_flt,
    output logic       match
);

    logic addr_eq;
    logic flt_hit;
    logic int_hit;

    // Float f0 is a real register; integer x0 is excluded from matching.
    always_comb begin
        addr_eq = (rd_addr == rs_addr);
        flt_hit = rd_wren_flt & rs_f;
        int_hit = rd_wren_int & ~rs_f & (rs_addr != REG_X0);
        match   = rs_use & addr_eq & (flt_hit | int_hit);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central hazard/stall controller: load-use stalls, branch flushes and
// memory-wait stalls with timeout abort, plus stall statistics.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_use_i,
    input  logic             id_rs2_use_i,
    input  logic             id_rs1_f_i,
    input  logic             id_rs2_f_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_rd_wren_I_i,
    input  logic             ex_rd_wren_F_i,
    input  logic             ex_is_load_i,
    input  logic             br_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             mem_wb_sel_o,
    output logic             mem_abort_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int WC_W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

    state_e            state_reg, state_next;
    logic [WC_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic              err_reg;

    logic              mem_wait;
    logic              mem_stall;
    logic              abort;
    logic              luh;
    logic [1:0]        rs_match;
    stall_ctrl_t       ctrl;

    logic [4:0] rs_addr [2];
    logic [1:0] rs_use;
    logic [1:0] rs_f;

    assign rs_addr[0] = id_rs1_addr_i;
    assign rs_addr[1] = id_rs2_addr_i;
    assign rs_use     = {id_rs2_use_i, id_rs1_use_i};
    assign rs_f       = {id_rs2_f_i, id_rs1_f_i};

    // One comparator per source operand.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_luh
            luh_detect u_luh_detect (
                .rs_addr     (rs_addr[gi]),
                .rs_use      (rs_use[gi]),
                .rs_f        (rs_f[gi]),
                .rd_addr     (ex_rd_addr_i),
                .rd_wren_int (ex_rd_wren_I_i),
                .rd_wren_flt (ex_rd_wren_F_i),
                .match       (rs_match[gi])
            );
        end
    endgenerate

    assign luh      = ex_is_load_i & (ex_rd_wren_I_i | ex_rd_wren_F_i) & (|rs_match);
    assign mem_wait = mem_req_i & ~mem_ready_i;

    // Memory-wait FSM: decides stall/abort for this cycle and the next state.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_stall     = 1'b0;
        abort         = 1'b0;
        case (state_reg)
            RUN: begin
                if (mem_wait) begin
                    mem_stall     = 1'b1;
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_wait && (wait_cnt_reg < WAIT_LAST)) begin
                    mem_stall     = 1'b1;
                    wait_cnt_next = wait_cnt_reg + WC_W'(1);
                end else begin
                    // Ready, request withdrawn, or timed out: release either way.
                    abort         = mem_wait;
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Stage controls by priority: reset > memory wait > branch > load-use.
    always_comb begin
        ctrl = CTRL_FLOW;
        if (i_rst) begin
            ctrl = CTRL_RESET;
        end else if (mem_stall) begin
            ctrl = CTRL_MEM_STALL;
        end else if (br_taken_i) begin
            // Dependent instruction is squashed by the flush, so luh is moot.
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (luh) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
        end
    end

    // FSM, timeout flag and stall statistics.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= RUN;
            wait_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (abort) begin
                err_reg <= 1'b1;
            end
            if (!ctrl.pc_en) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign pc_en_o       = ctrl.pc_en;
    assign if_id_en_o    = ctrl.if_id_en;
    assign id_ex_en_o    = ctrl.id_ex_en;
    assign ex_mem_en_o   = ctrl.ex_mem_en;
    assign if_id_flush_o = ctrl.if_id_flush;
    assign id_ex_flush_o = ctrl.id_ex_flush;
    assign mem_wb_sel_o  = ctrl.mem_wb_sel;
    assign mem_abort_o   = abort & ~i_rst;
    assign err_o         = err_reg;
    assign stall_cnt_o   = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, branch, memory wait,
// timeout abort and asynchronous reset mid-wait.
module tb_hazard_stall_ctrl;

    localparam int WAIT_MAX = 16;
    localparam int CNT_W    = 32;

    // Packed control view: {pc, if_id, id_ex, ex_mem, if_id_fl, id_ex_fl, wb_sel, abort}
    localparam logic [7:0] C_FLOW   = 8'b1111_0000;
    localparam logic [7:0] C_LUH    = 8'b0011_0100;
    localparam logic [7:0] C_BR     = 8'b1111_1100;
    localparam logic [7:0] C_MSTALL = 8'b0000_0010;
    localparam logic [7:0] C_ABORT  = 8'b1111_0001;
    localparam logic [7:0] C_RESET  = 8'b0000_1110;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [4:0]       id_rs1_addr_i, id_rs2_addr_i;
    logic             id_rs1_use_i, id_rs2_use_i, id_rs1_f_i, id_rs2_f_i;
    logic [4:0]       ex_rd_addr_i;
    logic             ex_rd_wren_I_i, ex_rd_wren_F_i, ex_is_load_i;
    logic             br_taken_i, mem_req_i, mem_ready_i;
    logic             pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o;
    logic             if_id_flush_o, id_ex_flush_o, mem_wb_sel_o, mem_abort_o, err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 i_clk = ~i_clk;

    hazard_stall_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .id_rs1_use_i   (id_rs1_use_i),
        .id_rs2_use_i   (id_rs2_use_i),
        .id_rs1_f_i     (id_rs1_f_i),
        .id_rs2_f_i     (id_rs2_f_i),
        .ex_rd_addr_i   (ex_rd_addr_i),
        .ex_rd_wren_I_i (ex_rd_wren_I_i),
        .ex_rd_wren_F_i (ex_rd_wren_F_i),
        .ex_is_load_i   (ex_is_load_i),
        .br_taken_i     (br_taken_i),
        .mem_req_i      (mem_req_i),
        .mem_ready_i    (mem_ready_i),
        .pc_en_o        (pc_en_o),
        .if_id_en_o     (if_id_en_o),
        .id_ex_en_o     (id_ex_en_o),
        .ex_mem_en_o    (ex_mem_en_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_flush_o  (id_ex_flush_o),
        .mem_wb_sel_o   (mem_wb_sel_o),
        .mem_abort_o    (mem_abort_o),
        .err_o          (err_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    task automatic clear_inputs();
        id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
        id_rs1_use_i = 1'b0; id_rs2_use_i = 1'b0;
        id_rs1_f_i = 1'b0; id_rs2_f_i = 1'b0;
        ex_rd_addr_i = 5'd0; ex_rd_wren_I_i = 1'b0; ex_rd_wren_F_i = 1'b0;
        ex_is_load_i = 1'b0; br_taken_i = 1'b0;
        mem_req_i = 1'b0; mem_ready_i = 1'b0;
    endtask

    // Advance one clock; returns on the following falling edge.
    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic chk_ctrl(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o,
               if_id_flush_o, id_ex_flush_o, mem_wb_sel_o, mem_abort_o};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: ctrl observed %b expected %b", tag, obs, exp);
        end
        $display("vec %0d %s ctrl=%b", vectors, tag, obs);
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp_cnt, input logic exp_err);
        vectors++;
        assert (stall_cnt_o === exp_cnt && err_o === exp_err) else begin
            miscompares++;
            $error("FAIL %s: cnt/err observed %0d/%b expected %0d/%b",
                   tag, stall_cnt_o, err_o, exp_cnt, exp_err);
        end
        $display("vec %0d %s cnt=%0d err=%b", vectors, tag, stall_cnt_o, err_o);
    endtask

    initial begin
        clear_inputs();
        i_rst = 1'b1;
        #2;
        chk_ctrl("reset_ctrl", C_RESET);
        chk_cnt("reset_cnt", 0, 1'b0);
        @(negedge i_clk);
        tick();
        i_rst = 1'b0;
        #1 chk_ctrl("idle", C_FLOW);

        // 1. Integer load-use on rs1
        ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd5; ex_rd_wren_I_i = 1'b1;
        id_rs1_addr_i = 5'd5; id_rs1_use_i = 1'b1;
        #1 chk_ctrl("luh_int", C_LUH);
        chk_cnt("luh_int_pre", 0, 1'b0);
        tick();
        clear_inputs();
        #1 chk_ctrl("luh_int_after", C_FLOW);
        chk_cnt("luh_int_cnt", 1, 1'b0);

        // 2a. Integer x0 never matches
        ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd0; ex_rd_wren_I_i = 1'b1;
        id_rs1_addr_i = 5'd0; id_rs1_use_i = 1'b1;
        #1 chk_ctrl("x0_int", C_FLOW);
        tick();
        clear_inputs();
        // 2b. Float f0 is a real register
        ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd0; ex_rd_wren_F_i = 1'b1;
        id_rs2_addr_i = 5'd0; id_rs2_use_i = 1'b1; id_rs2_f_i = 1'b1;
        #1 chk_ctrl("f0_float", C_LUH);
        tick();
        clear_inputs();
        chk_cnt("f0_cnt", 2, 1'b0);
        // 2c. Integer rd vs float rs1 with same number
        ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd3; ex_rd_wren_I_i = 1'b1;
        id_rs1_addr_i = 5'd3; id_rs1_use_i = 1'b1; id_rs1_f_i = 1'b1;
        #1 chk_ctrl("int_vs_float", C_FLOW);
        // 2d. Matching address but operand not used
        id_rs1_f_i = 1'b0; id_rs1_use_i = 1'b0;
        #1 chk_ctrl("unused_operand", C_FLOW);
        tick();
        clear_inputs();

        // 3. Branch together with a load-use hazard
        ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd7; ex_rd_wren_I_i = 1'b1;
        id_rs2_addr_i = 5'd7; id_rs2_use_i = 1'b1; br_taken_i = 1'b1;
        #1 chk_ctrl("br_luh", C_BR);
        tick();
        clear_inputs();
        chk_cnt("br_cnt", 2, 1'b0);

        // 4. Three-cycle memory wait; a branch during the stall is ignored
        mem_req_i = 1'b1; mem_ready_i = 1'b0;
        #1 chk_ctrl("mwait_1", C_MSTALL);
        tick();
        br_taken_i = 1'b1;
        #1 chk_ctrl("mwait_2_br", C_MSTALL);
        tick();
        br_taken_i = 1'b0;
        #1 chk_ctrl("mwait_3", C_MSTALL);
        tick();
        mem_ready_i = 1'b1;
        #1 chk_ctrl("mwait_release", C_FLOW);
        tick();
        clear_inputs();
        chk_cnt("mwait_cnt", 5, 1'b0);

        // 5. Timeout: 15 stall cycles, abort on the 16th
        mem_req_i = 1'b1; mem_ready_i = 1'b0;
        for (int i = 0; i < WAIT_MAX - 1; i++) begin
            #1 chk_ctrl($sformatf("tmo_stall_%0d", i), C_MSTALL);
            tick();
        end
        #1 chk_ctrl("tmo_abort", C_ABORT);
        chk_cnt("tmo_pre_err", 20, 1'b0);
        tick();
        mem_req_i = 1'b0;
        #1 chk_ctrl("tmo_after", C_FLOW);
        chk_cnt("tmo_err", 20, 1'b1);
        // Normal one-cycle wait afterwards keeps err sticky
        mem_req_i = 1'b1;
        #1 chk_ctrl("post_wait", C_MSTALL);
        tick();
        mem_ready_i = 1'b1;
        #1 chk_ctrl("post_release", C_FLOW);
        tick();
        clear_inputs();
        chk_cnt("err_sticky", 21, 1'b1);

        // 6. Asynchronous reset in the middle of a wait
        mem_req_i = 1'b1;
        tick();
        chk_cnt("pre_rst_cnt", 22, 1'b1);
        i_rst = 1'b1;
        #1 chk_ctrl("async_rst", C_RESET);
        chk_cnt("async_rst_cnt", 0, 1'b0);
        tick();
        clear_inputs();
        i_rst = 1'b0;
        #1 chk_ctrl("rst_release", C_FLOW);
        tick();
        chk_cnt("rst_release_cnt", 0, 1'b0);
        // Back in RUN: a ready access does not stall
        mem_req_i = 1'b1; mem_ready_i = 1'b1;
        #1 chk_ctrl("run_ready", C_FLOW);
        tick();
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central hazard/stall controller for the 5-stage RV32 (I+F) pipeline.
- Drives the enable and flush controls of PC, IF_ID, ID_EX and EX_MEM, and the bubble-select `sel_i` of MEM_WB.
- Covers three hazard sources: load-use hazards, EX-stage branch redirects, and multi-cycle memory/peripheral waits (keypad/LSU), with a timeout abort.
- Keeps stall statistics and a sticky error flag.

Parameters:
- WAIT_MAX, 16, max cycles a memory wait may last before abort (>=2).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- id_rs1_addr_i  in  5  ID-stage rs1 address
- id_rs2_addr_i  in  5  ID-stage rs2 address
- id_rs1_use_i, id_rs2_use_i  in  1 each  operand actually read
- id_rs1_f_i, id_rs2_f_i  in  1 each  operand read from the float regfile
- ex_rd_addr_i  in  5  ID_EX destination address
- ex_rd_wren_I_i, ex_rd_wren_F_i  in  1 each  ID_EX int/float writeback enables
- ex_is_load_i  in  1  ID_EX instruction is a load
- br_taken_i  in  1  EX-stage branch/jump redirect
- mem_req_i  in  1  MEM-stage access in flight
- mem_ready_i  in  1  MEM-stage data valid this cycle
- pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o  out  1 each  stage enables (1 = advance)
- if_id_flush_o, id_ex_flush_o  out  1 each  insert bubble
- mem_wb_sel_o  out  1  MEM_WB bubble select (1 = zeros)
- mem_abort_o  out  1  one-cycle abort to LSU
- err_o  out  1  sticky timeout flag
- stall_cnt_o  out  CNT_W  total stalled cycles

Behaviour:
Reset and clocking:
- Reset is asynchronous and active-high; one clock (`i_clk`). Reset port is `i_rst`, clock port is `i_clk`.
- While `i_rst` is high: state=RUN, wait_cnt=0, stall_cnt_o=0, err_o=0.
- During reset all `*_en_o`=0, both flushes=1, mem_wb_sel_o=1, mem_abort_o=0.
- Reset mid-wait abandons the wait silently: no abort, no error.

Outputs and priority:
- All control outputs are combinational from the current state and inputs; same-cycle response.
- Defaults: enables=1, flushes=0, mem_wb_sel_o=0, mem_abort_o=0.
- Priority: memory wait > branch > load-use.

Load-use hazard (luh):
- luh = ex_is_load_i & (ex_rd_wren_I_i | ex_rd_wren_F_i) & match on rs1 or rs2.
- Match on rsN = id_rsN_use_i & (ex_rd_addr_i == id_rsN_addr_i) & regfile agreement.
- Regfile agreement: either ex_rd_wren_F_i & id_rsN_f_i, or ex_rd_wren_I_i & !id_rsN_f_i & addr != 0.
- Float x0 (f0) is a real register; integer x0 never matches.
- Response: pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, for exactly one cycle (the load then leaves EX).

Branch:
- br_taken_i gives if_id_flush_o=1 and id_ex_flush_o=1; all enables stay 1.
- A simultaneous luh is ignored: the dependent instruction is squashed anyway.

FSM, states RUN and MEM_WAIT:
- wait = mem_req_i & !mem_ready_i.
- RUN: if wait, stall this cycle and go to MEM_WAIT with wait_cnt=1.
- Stall means: pc/if_id/id_ex/ex_mem enables=0, all flushes=0, mem_wb_sel_o=1.
- MEM_WAIT, while wait and wait_cnt < WAIT_MAX-1: stall and increment wait_cnt.
- MEM_WAIT, on mem_ready_i: no stall this cycle (the load advances), state RUN, wait_cnt=0.
- MEM_WAIT, on wait with wait_cnt == WAIT_MAX-1 (timeout):
  - mem_abort_o=1 for one cycle and the stall is released that cycle.
  - err_o set (sticky until reset); state RUN, wait_cnt=0.
  - The LSU returns 0 data and drops mem_req_i on abort.
- MEM_WAIT, mem_req_i dropping without ready: release, go RUN, no error.
- branch or luh inputs seen during a stall are ignored; they are still present after release because the upstream stages are frozen.

Stall counter:
- stall_cnt_o increments by 1 on every cycle with pc_en_o=0 (luh or mem stall).
- Wraps modulo 2^CNT_W.

Decomposition:
- Shared package hazard_pkg: state enum (RUN, MEM_WAIT), the REG_X0 constant, and the stall-control struct {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_sel}.
- One natural sub-module: luh_detect, a combinational load-use comparator instantiated for rs1 and rs2.

Test Plan:
1. Load-use int: ex load rd=5 wren_I=1, id rs1=5 use=1 f=0 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt 0->1.
2. No false hazards:
   - ex rd=0 wren_I=1, rs1=0 -> no stall.
   - ex wren_F=1 rd=0, id rs2=0 f=1 use=1 -> stall.
   - int rd=3 vs float rs1=3 -> no stall.
3. Branch plus luh in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1, stall_cnt unchanged.
4. Mem wait: mem_req=1, ready=0 for 3 cycles, then ready=1 -> mem_wb_sel=1 and enables=0 for exactly 3 cycles, released on the 4th; stall_cnt +=3; err_o=0.
5. Timeout, WAIT_MAX=16, ready held 0 -> 15 stall cycles, then mem_abort_o=1 and release on cycle 16; err_o=1 and it stays 1 after a later normal wait.
6. Async reset asserted mid-MEM_WAIT (between clock edges) -> immediate enables=0, flushes=1, mem_wb_sel=1; after release: RUN, stall_cnt=0, err_o=0, no abort pulse.
